// File: rtl/irq_aggregator.sv
// -----------------------------------------------------------------------------
// irq_aggregator
//
// Interrupt controller that collects up to 16 peripheral irq lines (bit 0 is
// normally the interval timer), latches them into pending bits under a
// per-source edge/level mode, masks them with a per-source enable and drives
// one registered irq_out plus a lowest-index priority vector. The register
// interface is the same 16-bit, 8-word slave style as the timer.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   irq_in      raw interrupt requests (may be asynchronous to clk)
//   chipselect  slave select
//   address     word address (0 PENDING, 1 ENABLE, 2 EDGE_MODE, 3 STATUS,
//               4 VECTOR, 5 SW_SET, 6 RAW, 7 reserved)
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, one cycle latency
//   irq_out     registered |(PENDING & ENABLE)
// -----------------------------------------------------------------------------
module irq_aggregator #(
    parameter int          NUM_IRQ     = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] EDGE_RESET  = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               chipselect,
    input  logic [2:0]         address,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq_out
);

    // Every register is held 16 bits wide; bits at or above NUM_IRQ are
    // forced to zero in the next-state logic so they stay constant and are
    // trimmed away by synthesis.
    localparam logic [15:0] VALID_MASK = 16'((32'h1 << NUM_IRQ) - 32'h1);

    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] sync_d [SYNC_STAGES];
    logic [15:0] prev_sync_q, prev_sync_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] enable_q, enable_d;
    logic [15:0] edge_mode_q, edge_mode_d;
    logic [15:0] readdata_q, readdata_d;
    logic        irq_out_q, irq_out_d;

    logic [15:0] irq_in_ext;
    logic [15:0] sync_now;
    logic [15:0] set_bits;
    logic [15:0] clr_bits;
    logic [15:0] status;
    logic [15:0] vector;
    logic [3:0]  vector_idx;
    logic        wr_en;

    assign sync_now = sync_q[SYNC_STAGES-1];

    always_comb begin
        irq_in_ext                = '0;
        irq_in_ext[NUM_IRQ-1:0]   = irq_in;

        sync_d[0] = irq_in_ext & VALID_MASK;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_sync_d = sync_now;

        wr_en = chipselect & ~write_n;

        // Edge-mode sources set on a rising synchronised input, level-mode
        // sources set whenever the input is high; SW_SET forces either.
        set_bits = (edge_mode_q & sync_now & ~prev_sync_q)
                 | (~edge_mode_q & sync_now);
        if (wr_en && address == 3'd5) begin
            set_bits = set_bits | writedata;
        end
        clr_bits = '0;
        if (wr_en && address == 3'd0) begin
            clr_bits = writedata;
        end
        // Set wins over clear, so a level source still high re-asserts.
        pending_d = ((pending_q & ~clr_bits) | set_bits) & VALID_MASK;

        enable_d = enable_q;
        if (wr_en && address == 3'd1) begin
            enable_d = writedata & VALID_MASK;
        end
        edge_mode_d = edge_mode_q;
        if (wr_en && address == 3'd2) begin
            edge_mode_d = writedata & VALID_MASK;
        end

        status = pending_q & enable_q;

        // Scan from the top down so the lowest set index is the one kept.
        vector_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (status[i]) begin
                vector_idx = 4'(i);
            end
        end
        vector = {|status, 11'd0, vector_idx};

        // Mux from pre-write state: a read coinciding with a write sees the
        // old value.
        case (address)
            3'd0:    readdata_d = pending_q;
            3'd1:    readdata_d = enable_q;
            3'd2:    readdata_d = edge_mode_q;
            3'd3:    readdata_d = status;
            3'd4:    readdata_d = vector;
            3'd6:    readdata_d = sync_now;
            default: readdata_d = 16'h0000;
        endcase

        irq_out_d = |status;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_sync_q <= '0;
            pending_q   <= '0;
            enable_q    <= '0;
            edge_mode_q <= EDGE_RESET & VALID_MASK;
            readdata_q  <= '0;
            irq_out_q   <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_sync_q <= prev_sync_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            edge_mode_q <= edge_mode_d;
            readdata_q  <= readdata_d;
            irq_out_q   <= irq_out_d;
        end
    end

    assign readdata = readdata_q;
    assign irq_out  = irq_out_q;

endmodule
